// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: valid/ready command front end that drives the 8-bit ALU with a load-then-persist sequence.
// Revision 1.0
`default_nettype none

module alu_cmd_sequencer #(
  parameter int LATENCY = 2,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [7:0]       cmd_a,
  input  logic [7:0]       cmd_b,
  output logic             alu_on,
  output logic [2:0]       alu_in_sel,
  output logic [7:0]       alu_num1,
  output logic [7:0]       alu_num2,
  output logic [6:0]       alu_out_sel,
  input  logic [7:0]       alu_out,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [7:0]       rsp_data,
  output logic [2:0]       rsp_op,
  output logic             rsp_err,
  output logic             busy,
  output logic [CNT_W-1:0] txn_count
);

  localparam logic [2:0] IN_IDLE    = 3'b000;
  localparam logic [2:0] IN_LOAD    = 3'b010;
  localparam logic [2:0] IN_PERSIST = 3'b100;
  localparam logic [2:0] OP_ILLEGAL = 3'd7;
  localparam logic [3:0] WAIT_INIT  = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, LOAD, WAIT, RESP} state_t;

  state_t           state, state_nx;
  logic [3:0]       wait_cnt, wait_cnt_nx;
  logic             cmd_ready_nx, alu_on_nx, rsp_valid_nx, rsp_err_nx, busy_nx;
  logic [2:0]       in_sel_nx, rsp_op_nx;
  logic [7:0]       num1_nx, num2_nx, rsp_data_nx;
  logic [6:0]       out_sel_nx;
  logic [CNT_W-1:0] txn_count_nx;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      cmd_ready   <= 1'b0;
      alu_on      <= 1'b0;
      alu_in_sel  <= IN_IDLE;
      alu_num1    <= '0;
      alu_num2    <= '0;
      alu_out_sel <= '0;
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
      rsp_op      <= '0;
      rsp_err     <= 1'b0;
      busy        <= 1'b0;
      txn_count   <= '0;
    end else begin
      state       <= state_nx;
      wait_cnt    <= wait_cnt_nx;
      cmd_ready   <= cmd_ready_nx;
      alu_on      <= alu_on_nx;
      alu_in_sel  <= in_sel_nx;
      alu_num1    <= num1_nx;
      alu_num2    <= num2_nx;
      alu_out_sel <= out_sel_nx;
      rsp_valid   <= rsp_valid_nx;
      rsp_data    <= rsp_data_nx;
      rsp_op      <= rsp_op_nx;
      rsp_err     <= rsp_err_nx;
      busy        <= busy_nx;
      txn_count   <= txn_count_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    wait_cnt_nx  = wait_cnt;
    alu_on_nx    = 1'b1;
    in_sel_nx    = alu_in_sel;
    num1_nx      = alu_num1;
    num2_nx      = alu_num2;
    out_sel_nx   = alu_out_sel;
    rsp_valid_nx = rsp_valid;
    rsp_data_nx  = rsp_data;
    rsp_op_nx    = rsp_op;
    rsp_err_nx   = rsp_err;
    txn_count_nx = txn_count;

    case (state)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          rsp_op_nx = cmd_op;
          // An illegal opcode never touches the ALU; it is answered directly.
          if (cmd_op == OP_ILLEGAL) begin
            state_nx     = RESP;
            rsp_valid_nx = 1'b1;
            rsp_err_nx   = 1'b1;
            rsp_data_nx  = 8'h00;
          end else begin
            state_nx   = LOAD;
            in_sel_nx  = IN_LOAD;
            num1_nx    = cmd_a;
            num2_nx    = cmd_b;
            out_sel_nx = 7'b1000000 >> cmd_op;
          end
        end
      end
      LOAD: begin
        state_nx    = WAIT;
        in_sel_nx   = IN_PERSIST;
        wait_cnt_nx = WAIT_INIT;
      end
      WAIT: begin
        if (wait_cnt == 4'd0) begin
          state_nx     = RESP;
          rsp_valid_nx = 1'b1;
          rsp_err_nx   = 1'b0;
          rsp_data_nx  = alu_out;
          in_sel_nx    = IN_IDLE;
          out_sel_nx   = '0;
        end else begin
          wait_cnt_nx = wait_cnt - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_nx     = IDLE;
          rsp_valid_nx = 1'b0;
          txn_count_nx = txn_count + CNT_W'(1);
        end
      end
      default: state_nx = IDLE;
    endcase

    cmd_ready_nx = (state_nx == IDLE);
    busy_nx      = (state_nx != IDLE);
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_cmd_sequencer.sv
// tb_alu_cmd_sequencer: scoreboard bench for alu_cmd_sequencer with a latency-accurate ALU stub.
// Revision 1.0
`default_nettype none

module tb_alu_cmd_sequencer;

  typedef struct packed {
    logic [7:0] data;
    logic [2:0] op;
    logic       err;
  } rsp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid1, cmd_valid2;
  logic [2:0] cmd_op;
  logic [7:0] cmd_a, cmd_b;
  logic       rsp_ready;

  logic       cmd_ready1, alu_on1, rsp_valid1, rsp_err1, busy1;
  logic [2:0] in_sel1, rsp_op1;
  logic [7:0] num1_1, num2_1, alu_out1, rsp_data1;
  logic [6:0] out_sel1;
  logic [15:0] txn1;

  logic       cmd_ready2, alu_on2, rsp_valid2, rsp_err2, busy2;
  logic [2:0] in_sel2, rsp_op2;
  logic [7:0] num1_2, num2_2, alu_out2, rsp_data2;
  logic [6:0] out_sel2;
  logic [1:0] txn2;

  int   n_cmp = 0;
  int   n_err = 0;
  rsp_t exp_q[$];

  always #5 clk = ~clk;

  alu_cmd_sequencer dut1 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b), .alu_on(alu_on1),
    .alu_in_sel(in_sel1), .alu_num1(num1_1), .alu_num2(num2_1),
    .alu_out_sel(out_sel1), .alu_out(alu_out1), .rsp_valid(rsp_valid1),
    .rsp_ready(rsp_ready), .rsp_data(rsp_data1), .rsp_op(rsp_op1),
    .rsp_err(rsp_err1), .busy(busy1), .txn_count(txn1)
  );

  alu_cmd_sequencer #(.LATENCY(1), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid2), .cmd_ready(cmd_ready2),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b), .alu_on(alu_on2),
    .alu_in_sel(in_sel2), .alu_num1(num1_2), .alu_num2(num2_2),
    .alu_out_sel(out_sel2), .alu_out(alu_out2), .rsp_valid(rsp_valid2),
    .rsp_ready(rsp_ready), .rsp_data(rsp_data2), .rsp_op(rsp_op2),
    .rsp_err(rsp_err2), .busy(busy2), .txn_count(txn2)
  );

  // Reference operation set, indexed by opcode.
  function automatic logic [7:0] model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      3'd5:    return a << 1;
      3'd6:    return a >> 1;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] alu_fn(input logic [7:0] a, input logic [7:0] b, input logic [6:0] sel);
    case (sel)
      7'b1000000: return model(3'd0, a, b);
      7'b0100000: return model(3'd1, a, b);
      7'b0010000: return model(3'd2, a, b);
      7'b0001000: return model(3'd3, a, b);
      7'b0000100: return model(3'd4, a, b);
      7'b0000010: return model(3'd5, a, b);
      7'b0000001: return model(3'd6, a, b);
      default:    return 8'hA5;
    endcase
  endfunction

  // ALU stubs: the result is only correct exactly LATENCY cycles after the load cycle.
  logic [3:0] age1, age2;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      age1 <= 4'd0;
      age2 <= 4'd0;
    end else begin
      age1 <= (in_sel1 == 3'b010) ? 4'd1 : (in_sel1 == 3'b100) ? age1 + 4'd1 : 4'd0;
      age2 <= (in_sel2 == 3'b010) ? 4'd1 : (in_sel2 == 3'b100) ? age2 + 4'd1 : 4'd0;
    end
  end
  assign alu_out1 = (age1 == 4'd2) ? alu_fn(num1_1, num2_1, out_sel1) : ~alu_fn(num1_1, num2_1, out_sel1);
  assign alu_out2 = (age2 == 4'd1) ? alu_fn(num1_2, num2_2, out_sel2) : ~alu_fn(num1_2, num2_2, out_sel2);

  logic        s;
  logic        m_cmd_ready, m_rsp_valid, m_rsp_err, m_busy;
  logic [2:0]  m_rsp_op;
  logic [7:0]  m_rsp_data;
  logic [15:0] m_txn;
  assign m_cmd_ready = s ? cmd_ready2 : cmd_ready1;
  assign m_rsp_valid = s ? rsp_valid2 : rsp_valid1;
  assign m_rsp_err   = s ? rsp_err2   : rsp_err1;
  assign m_busy      = s ? busy2      : busy1;
  assign m_rsp_op    = s ? rsp_op2    : rsp_op1;
  assign m_rsp_data  = s ? rsp_data2  : rsp_data1;
  assign m_txn       = s ? {14'd0, txn2} : txn1;

  task automatic issue(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    rsp_t e;
    int   n = 0;
    while (m_cmd_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      n_cmp++;
      n_err++;
      $display("FAIL issue_timeout: cmd_ready=%b, required 1", m_cmd_ready);
    end
    cmd_op = op;
    cmd_a  = a;
    cmd_b  = b;
    if (s) cmd_valid2 = 1'b1;
    else   cmd_valid1 = 1'b1;
    e.data = model(op, a, b);
    e.op   = op;
    e.err  = (op == 3'd7);
    exp_q.push_back(e);
    @(negedge clk);
    cmd_valid1 = 1'b0;
    cmd_valid2 = 1'b0;
    cmd_a      = ~a;
    cmd_b      = ~b;
  endtask

  task automatic wait_rsp(output int lat, input bit do_ack);
    rsp_t e;
    lat = 1;
    while (m_rsp_valid !== 1'b1 && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    n_cmp++;
    if (m_rsp_valid !== 1'b1) begin
      n_err++;
      $display("FAIL rsp_timeout: rsp_valid=%b after %0d cycles, required 1", m_rsp_valid, lat);
    end else if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL rsp_unexpected: response seen with empty scoreboard, required none");
    end else begin
      e = exp_q.pop_front();
      if ({m_rsp_data, m_rsp_op, m_rsp_err} !== {e.data, e.op, e.err}) begin
        n_err++;
        $display("FAIL rsp_payload: data=%h op=%0d err=%b, required data=%h op=%0d err=%b",
                 m_rsp_data, m_rsp_op, m_rsp_err, e.data, e.op, e.err);
      end
    end
    if (do_ack) begin
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      n_cmp++;
      if (m_rsp_valid !== 1'b0) begin
        n_err++;
        $display("FAIL rsp_drop: rsp_valid=%b after handshake, required 0", m_rsp_valid);
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_cmp++;
    if ({alu_on1, cmd_ready1, in_sel1, num1_1, num2_1, out_sel1, rsp_valid1, rsp_data1,
         rsp_op1, rsp_err1, busy1, txn1} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: on=%b rdy=%b in_sel=%b out_sel=%b rv=%b busy=%b txn=%0d, required all 0",
               alu_on1, cmd_ready1, in_sel1, out_sel1, rsp_valid1, busy1, txn1);
    end
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({alu_on1, cmd_ready1, busy1} !== 3'b110) begin
      n_err++;
      $display("FAIL reset_release: on/rdy/busy=%b, required 110", {alu_on1, cmd_ready1, busy1});
    end
  endtask

  task automatic test_reset_mid_wait();
    int seen = 0;
    s = 1'b0;
    issue(3'd0, 8'h11, 8'h22);
    @(negedge clk);
    n_cmp++;
    if (in_sel1 !== 3'b100) begin
      n_err++;
      $display("FAIL rmw_in_wait: in_sel=%b, required 100", in_sel1);
    end
    #2 rst = 1'b0;
    #1;
    n_cmp++;
    if ({alu_on1, cmd_ready1, in_sel1, num1_1, num2_1, out_sel1, rsp_valid1, busy1, txn1} !== '0) begin
      n_err++;
      $display("FAIL rmw_async_clear: on=%b in_sel=%b out_sel=%b rv=%b busy=%b, required all 0",
               alu_on1, in_sel1, out_sel1, rsp_valid1, busy1);
    end
    exp_q.delete();
    @(negedge clk);
    rst = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (rsp_valid1 !== 1'b0 || busy1 !== 1'b0) seen++;
    end
    n_cmp++;
    if (seen != 0 || txn1 !== 16'd0) begin
      n_err++;
      $display("FAIL rmw_dropped: %0d cycles with rsp_valid/busy, txn=%0d, required 0 and 0", seen, txn1);
    end
  endtask

  task automatic test_basic();
    int lat;
    s = 1'b0;
    issue(3'd0, 8'h57, 8'h1A);
    n_cmp++;
    if ({in_sel1, out_sel1, num1_1, num2_1, cmd_ready1, busy1} !== {3'b010, 7'b1000000, 8'h57, 8'h1A, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL basic_load: in_sel=%b out_sel=%b n1=%h n2=%h rdy=%b busy=%b, required 010 1000000 57 1a 0 1",
               in_sel1, out_sel1, num1_1, num2_1, cmd_ready1, busy1);
    end
    repeat (2) begin
      @(negedge clk);
      n_cmp++;
      if ({in_sel1, out_sel1, num1_1, num2_1, rsp_valid1} !== {3'b100, 7'b1000000, 8'h57, 8'h1A, 1'b0}) begin
        n_err++;
        $display("FAIL basic_persist: in_sel=%b out_sel=%b n1=%h n2=%h rv=%b, required 100 1000000 57 1a 0",
                 in_sel1, out_sel1, num1_1, num2_1, rsp_valid1);
      end
    end
    @(negedge clk);
    n_cmp++;
    if ({rsp_valid1, rsp_data1, in_sel1, out_sel1} !== {1'b1, 8'h71, 3'b000, 7'b0}) begin
      n_err++;
      $display("FAIL basic_resp: rv=%b data=%h in_sel=%b out_sel=%b, required 1 71 000 0000000",
               rsp_valid1, rsp_data1, in_sel1, out_sel1);
    end
    wait_rsp(lat, 1'b1);
    n_cmp++;
    if (txn1 !== 16'd1) begin
      n_err++;
      $display("FAIL basic_txn: txn=%0d, required 1", txn1);
    end
  endtask

  task automatic test_op_sweep();
    int          lat;
    logic [15:0] base;
    logic [6:0]  top;
    logic [6:0]  exp_sel;
    s    = 1'b0;
    base = txn1;
    top  = 7'b1000000;
    for (int op = 0; op < 7; op++) begin
      exp_sel = top >> op;
      issue(3'(op), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      n_cmp++;
      if ({out_sel1, cmd_ready1, busy1} !== {exp_sel, 1'b0, 1'b1}) begin
        n_err++;
        $display("FAIL sweep_sel op%0d: out_sel=%b rdy=%b busy=%b, required %b 0 1",
                 op, out_sel1, cmd_ready1, busy1, exp_sel);
      end
      wait_rsp(lat, 1'b1);
      n_cmp++;
      if (lat != 4) begin
        n_err++;
        $display("FAIL sweep_latency op%0d: rsp_valid at cycle %0d after accept, required 4", op, lat);
      end
    end
    n_cmp++;
    if (txn1 !== base + 16'd7) begin
      n_err++;
      $display("FAIL sweep_txn: txn=%0d, required %0d", txn1, base + 16'd7);
    end
  endtask

  task automatic test_illegal();
    int          lat;
    logic [15:0] base;
    s    = 1'b0;
    base = txn1;
    issue(3'd7, 8'hC3, 8'h3C);
    n_cmp++;
    if ({rsp_valid1, rsp_err1, rsp_data1, in_sel1, out_sel1} !== {1'b1, 1'b1, 8'h00, 3'b000, 7'b0}) begin
      n_err++;
      $display("FAIL illegal_resp: rv=%b err=%b data=%h in_sel=%b out_sel=%b, required 1 1 00 000 0000000",
               rsp_valid1, rsp_err1, rsp_data1, in_sel1, out_sel1);
    end
    wait_rsp(lat, 1'b1);
    n_cmp++;
    if (lat != 1 || txn1 !== base + 16'd1) begin
      n_err++;
      $display("FAIL illegal_txn: latency=%0d txn=%0d, required 1 and %0d", lat, txn1, base + 16'd1);
    end
  endtask

  task automatic test_backpressure();
    int          lat;
    int          bad = 0;
    logic [7:0]  held;
    logic [15:0] base;
    s    = 1'b0;
    base = txn1;
    issue(3'd3, 8'h5A, 8'h81);
    wait_rsp(lat, 1'b0);
    held       = rsp_data1;
    cmd_op     = 3'd5;
    cmd_valid1 = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (rsp_valid1 !== 1'b1 || rsp_data1 !== held || cmd_ready1 !== 1'b0 || rsp_op1 !== 3'd3) bad++;
    end
    n_cmp++;
    if (bad != 0 || txn1 !== base) begin
      n_err++;
      $display("FAIL bp_stall: %0d unstable cycles, txn=%0d, required 0 and %0d", bad, txn1, base);
    end
    cmd_valid1 = 1'b0;
    rsp_ready  = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    n_cmp++;
    if ({rsp_valid1, busy1, cmd_ready1} !== 3'b001 || txn1 !== base + 16'd1) begin
      n_err++;
      $display("FAIL bp_release: rv/busy/rdy=%b txn=%0d, required 001 and %0d",
               {rsp_valid1, busy1, cmd_ready1}, txn1, base + 16'd1);
    end
  endtask

  task automatic test_wrap_latency1();
    int         lat;
    logic [1:0] exp_txn;
    s = 1'b1;
    for (int i = 0; i < 5; i++) begin
      exp_txn = 2'(i + 1);
      issue(3'(i), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      wait_rsp(lat, 1'b1);
      n_cmp++;
      if (lat != 3 || txn2 !== exp_txn) begin
        n_err++;
        $display("FAIL wrap_cmd%0d: latency=%0d txn=%0d, required 3 and %0d", i, lat, txn2, exp_txn);
      end
    end
    s = 1'b0;
  endtask

  initial begin
    rst        = 1'b0;
    s          = 1'b0;
    cmd_valid1 = 1'b0;
    cmd_valid2 = 1'b0;
    cmd_op     = 3'd0;
    cmd_a      = 8'd0;
    cmd_b      = 8'd0;
    rsp_ready  = 1'b0;
    test_reset();
    test_reset_mid_wait();
    test_basic();
    test_op_sweep();
    test_illegal();
    test_backpressure();
    test_wrap_latency1();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
